// File: rtl/id_insn_queue_pkg.sv
// Shared sizing for the ID-stage instruction queue.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   IQ_DEPTH, IQ_ADDR_W, IQ_DATA_W  default queue geometry
//   IQ_PTR_W, IQ_CNT_W              pointer and occupancy widths
//   iq_ptr_t, iq_cnt_t              typed pointer and occupancy ranges
//   iq_entry_t                      one queued (pc, insn) pair
package id_insn_queue_pkg;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_ADDR_W = 30;
  localparam int IQ_DATA_W = 32;

  // A pointer covers exactly DEPTH slots, so it wraps on natural binary overflow.
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH);
  // One extra code is needed so that count==DEPTH (full) is representable.
  localparam int IQ_CNT_W = $clog2(IQ_DEPTH + 1);

  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

  typedef struct packed {
    logic [IQ_ADDR_W-1:0] pc;
    logic [IQ_DATA_W-1:0] insn;
  } iq_entry_t;

endpackage

// File: rtl/id_insn_queue_mem.sv
// Purpose: DEPTH x WIDTH register array holding the queued entries.
// Latency: write lands on the clock edge; the read port is combinational.
// Backpressure: none; the caller decides when a write is legal.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   write data
//   raddr  in   read slot
//   rdata  out  contents of slot raddr
//
// The array has no reset. Reads of a slot that has not been written are
// masked by the queue's empty check, so their contents never escape.
module iq_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 62
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_insn_queue.sv
// Purpose: in-order (pc, insn) queue between the IF/ID register and the ID decoder.
// Latency: 1 cycle from if_en to q_en; no write-to-read bypass.
// Backpressure: if_stall=1 while full (held upstream); id_stall=1 holds the head stable.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous reset, active-high
//   if_pc     in   PC of the fetched instruction
//   if_insn   in   fetched instruction
//   if_en     in   if_pc/if_insn valid
//   if_stall  out  stall request to IF; 1 = queue full
//   flush     in   pipeline flush; empties the queue on the next edge
//   id_stall  in   decoder cannot accept the head this cycle
//   q_pc      out  head-entry PC (0 when empty)
//   q_insn    out  head-entry instruction (0 when empty)
//   q_en      out  head entry valid
//   q_count   out  current occupancy
module id_insn_queue
  import id_insn_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [DATA_W-1:0]          if_insn,
  input  logic                       if_en,
  output logic                       if_stall,
  input  logic                       flush,
  input  logic                       id_stall,
  output logic [ADDR_W-1:0]          q_pc,
  output logic [DATA_W-1:0]          q_insn,
  output logic                       q_en,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head_dat;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Flush suppresses both push and pop, so any traffic in the flush cycle is
  // discarded. push needs ~full and pop needs ~empty, which rules out the
  // push&pop-while-full and push&pop-while-empty corner cases by construction.
  assign push = if_en & ~full & ~flush;
  assign pop  = ~empty & ~id_stall & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so +1 wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  iq_mem #(
    .DEPTH(DEPTH),
    .WIDTH(ENT_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata({if_pc, if_insn}),
    .raddr(rd_ptr_q),
    .rdata(head_dat)
  );

  // Head outputs derive only from registered state, so there is no
  // combinational path from id_stall or if_en to any output. Masking with
  // empty hides stale or never-written storage.
  assign q_en     = ~empty;
  assign q_pc     = empty ? '0 : head_dat[ENT_W-1:DATA_W];
  assign q_insn   = empty ? '0 : head_dat[DATA_W-1:0];
  assign q_count  = count_q;
  assign if_stall = full;

endmodule

// File: tb/tb_id_insn_queue.sv
// Directed self-checking bench for id_insn_queue.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Expected values are hand-derived constants per scenario.
module tb_id_insn_queue;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic              if_en;
  logic              if_stall;
  logic              flush;
  logic              id_stall;
  logic [ADDR_W-1:0] q_pc;
  logic [DATA_W-1:0] q_insn;
  logic              q_en;
  logic [2:0]        q_count;

  int pass_cnt;
  int total_cnt;

  id_insn_queue #(
    .DEPTH (4),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .if_pc   (if_pc),
    .if_insn (if_insn),
    .if_en   (if_en),
    .if_stall(if_stall),
    .flush   (flush),
    .id_stall(id_stall),
    .q_pc    (q_pc),
    .q_insn  (q_insn),
    .q_en    (q_en),
    .q_count (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_en = 1'b0; flush = 1'b0; id_stall = 1'b0;
    if_pc = '0; if_insn = '0;
    #3;
    total_cnt++;
    if ({q_en, q_count, if_stall} !== 5'b0) $display("FAIL reset_assert: got en/cnt/stall=%b want 0", {q_en, q_count, if_stall});
    else pass_cnt++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (q_en !== 1'b0 || q_count !== 3'd0 || if_stall !== 1'b0 || q_pc !== '0 || q_insn !== '0)
        $display("FAIL reset_idle[%0d]: got en=%b cnt=%0d stall=%b pc=%h insn=%h want all 0",
                 i, q_en, q_count, if_stall, q_pc, q_insn);
      else pass_cnt++;
    end
  endtask

  task automatic test_order();
    id_stall = 1'b0;
    if_en = 1'b1; if_pc = 30'h100; if_insn = 32'hA0;
    #1;
    total_cnt++;
    if (q_en !== 1'b0) $display("FAIL order_latency: got q_en=%b want 0 before first edge", q_en);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step();
      // Each edge pushes entry k and pops entry k-1: the head is entry k.
      total_cnt++;
      if (q_en !== 1'b1 || q_pc !== 30'(32'h100 + k) || q_insn !== 32'hA0 + k || q_count !== 3'd1)
        $display("FAIL order_head[%0d]: got en=%b pc=%h insn=%h cnt=%0d want 1 %h %h 1",
                 k, q_en, q_pc, q_insn, q_count, 32'h100 + k, 32'hA0 + k);
      else pass_cnt++;
      if (k < 3) begin
        if_pc = 30'(32'h101 + k); if_insn = 32'hA1 + k;
      end else begin
        if_en = 1'b0;
      end
    end
    step();
    total_cnt++;
    if (q_en !== 1'b0 || q_count !== 3'd0) $display("FAIL order_drain: got en=%b cnt=%0d want 0 0", q_en, q_count);
    else pass_cnt++;
  endtask

  task automatic test_fill_hold();
    id_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_en = 1'b1; if_pc = 30'(32'h10 + k); if_insn = 32'hB0 + k;
      step();
    end
    total_cnt++;
    if (if_stall !== 1'b1 || q_count !== 3'd4 || q_pc !== 30'h10)
      $display("FAIL fill_full: got stall=%b cnt=%0d head=%h want 1 4 10", if_stall, q_count, q_pc);
    else pass_cnt++;
    // 0x14 presented while full: refused and held upstream.
    if_pc = 30'h14; if_insn = 32'hB4;
    step();
    total_cnt++;
    if (if_stall !== 1'b1 || q_count !== 3'd4 || q_pc !== 30'h10)
      $display("FAIL fill_refuse: got stall=%b cnt=%0d head=%h want 1 4 10", if_stall, q_count, q_pc);
    else pass_cnt++;
    id_stall = 1'b0;
    step();
    total_cnt++;
    if (if_stall !== 1'b0 || q_count !== 3'd3 || q_pc !== 30'h11)
      $display("FAIL fill_release: got stall=%b cnt=%0d head=%h want 0 3 11", if_stall, q_count, q_pc);
    else pass_cnt++;
    id_stall = 1'b1;
    step();
    if_en = 1'b0;
    total_cnt++;
    if (if_stall !== 1'b1 || q_count !== 3'd4)
      $display("FAIL fill_repush: got stall=%b cnt=%0d want 1 4", if_stall, q_count);
    else pass_cnt++;
    id_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (q_en !== 1'b1 || q_pc !== 30'(32'h11 + k) || q_insn !== 32'hB1 + k)
        $display("FAIL fill_drain[%0d]: got en=%b pc=%h insn=%h want 1 %h %h",
                 k, q_en, q_pc, q_insn, 32'h11 + k, 32'hB1 + k);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (q_en !== 1'b0 || q_count !== 3'd0) $display("FAIL fill_nodup: got en=%b cnt=%0d want 0 0", q_en, q_count);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    id_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_en = 1'b1; if_pc = 30'(32'h30 + k); if_insn = 32'hC0 + k;
      step();
    end
    total_cnt++;
    if (q_count !== 3'd3) $display("FAIL flush_prefill: got cnt=%0d want 3", q_count);
    else pass_cnt++;
    flush = 1'b1; id_stall = 1'b0; if_pc = 30'h33; if_insn = 32'hC3;
    step();
    total_cnt++;
    if (q_count !== 3'd0 || q_en !== 1'b0 || q_pc !== '0)
      $display("FAIL flush_clear: got cnt=%0d en=%b pc=%h want 0 0 0", q_count, q_en, q_pc);
    else pass_cnt++;
    flush = 1'b0; if_pc = 30'h200; if_insn = 32'h55;
    step();
    if_en = 1'b0; id_stall = 1'b1;
    total_cnt++;
    if (q_en !== 1'b1 || q_pc !== 30'h200 || q_insn !== 32'h55 || q_count !== 3'd1)
      $display("FAIL flush_newpush: got en=%b pc=%h insn=%h cnt=%0d want 1 200 55 1", q_en, q_pc, q_insn, q_count);
    else pass_cnt++;
    id_stall = 1'b0;
    step();
    total_cnt++;
    if (q_count !== 3'd0) $display("FAIL flush_drain: got cnt=%0d want 0", q_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int exp_pc;
    exp_pc = 0;
    for (int r = 0; r < 3; r++) begin
      id_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if_en = 1'b1; if_pc = 30'(r * 4 + k); if_insn = 32'hD00 + r * 4 + k;
        step();
      end
      if_en = 1'b0;
      total_cnt++;
      if (if_stall !== 1'b1 || q_count !== 3'd4)
        $display("FAIL wrap_full[%0d]: got stall=%b cnt=%0d want 1 4", r, if_stall, q_count);
      else pass_cnt++;
      id_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (q_pc !== 30'(exp_pc) || q_insn !== 32'hD00 + exp_pc)
          $display("FAIL wrap_seq[%0d]: got pc=%h insn=%h want %h %h", exp_pc, q_pc, q_insn, exp_pc, 32'hD00 + exp_pc);
        else pass_cnt++;
        exp_pc++;
        step();
      end
    end
    total_cnt++;
    if (q_en !== 1'b0 || q_count !== 3'd0) $display("FAIL wrap_empty: got en=%b cnt=%0d want 0 0", q_en, q_count);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    id_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_en = 1'b1; if_pc = 30'(32'h60 + k); if_insn = 32'hE0 + k;
      step();
    end
    if_en = 1'b0;
    total_cnt++;
    if (q_count !== 3'd2) $display("FAIL areset_prefill: got cnt=%0d want 2", q_count);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (q_en !== 1'b0 || q_count !== 3'd0 || if_stall !== 1'b0 || q_pc !== '0)
      $display("FAIL areset_immediate: got en=%b cnt=%0d stall=%b pc=%h want 0 0 0 0", q_en, q_count, if_stall, q_pc);
    else pass_cnt++;
    reset = 1'b0;
    if_en = 1'b1; if_pc = 30'h77; if_insn = 32'hF7;
    step();
    if_en = 1'b0;
    total_cnt++;
    if (q_en !== 1'b1 || q_pc !== 30'h77 || q_insn !== 32'hF7 || q_count !== 3'd1)
      $display("FAIL areset_resume: got en=%b pc=%h insn=%h cnt=%0d want 1 77 f7 1", q_en, q_pc, q_insn, q_count);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_order();
    test_fill_hold();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
